// File: rtl/common_pkg.sv
// Shared definitions for the SPI-to-Wishbone bridge.
// Holds the bus widths, the command-byte bit positions and the bridge
// FSM state type so the top level and the bench agree on them.
package common_pkg;

  localparam int WB_ADDR_WIDTH = 20;
  localparam int DATA_WIDTH    = 8;

  // Command byte layout: bit 7 selects write, bit 6 selects auto-increment,
  // bits 3:0 carry addr[19:16].
  localparam int SPI_CMD_WRITE_BIT = 7;
  localparam int SPI_CMD_INCR_BIT  = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_WB_REQ  = 3'd4,
    ST_WB_WAIT = 3'd5
  } spi_wb_state_t;

endpackage

// File: rtl/wb_master_port.sv
// Single-access Wishbone B4 pipelined master handshake.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   req_i, we_i       start one access (ignored while a cycle is open)
//   wb_stall_i        slave stall; strobe is held while it is high
//   wb_ack_i          slave acknowledge; closes the cycle
//   wb_cycle_o        CYC, raised with the strobe, dropped on the ack edge
//   wb_strobe_o       STB, exactly one accepted strobe per request
//   wb_we_o           write enable latched with the request
//   done_o            combinational: the ack is being consumed this cycle
module wb_master_port (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic we_i,
  input  logic wb_stall_i,
  input  logic wb_ack_i,
  output logic wb_cycle_o,
  output logic wb_strobe_o,
  output logic wb_we_o,
  output logic done_o
);

  logic cyc_q, cyc_d;
  logic stb_q, stb_d;
  logic we_q, we_d;

  always_comb begin
    cyc_d  = cyc_q;
    stb_d  = stb_q;
    we_d   = we_q;
    done_o = 1'b0;
    if (!cyc_q) begin
      if (req_i) begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d  = we_i;
      end
    end else if (stb_q) begin
      // The strobe is accepted on the first edge without stall.
      if (!wb_stall_i) begin
        stb_d = 1'b0;
      end
    end else if (wb_ack_i) begin
      cyc_d  = 1'b0;
      done_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      stb_q <= stb_d;
      we_q  <= we_d;
    end
  end

  assign wb_cycle_o  = cyc_q;
  assign wb_strobe_o = stb_q;
  assign wb_we_o     = we_q;

endmodule

// File: rtl/spi_wb_bridge.sv
// SPI byte stream to Wishbone B4 pipelined master bridge.
// A frame is: cmd byte, addr[15:8], addr[7:0], then data bytes. Writes send
// each data byte to the bus; reads fetch one byte up front and one more per
// dummy byte clocked in, presenting the result on spi_tx_data_o.
// Ports:
//   wb_clock_i, wb_reset_i          clock, asynchronous active-high reset
//   spi_cs_n_i                      synchronized chip select (low = frame)
//   spi_rx_valid_i, spi_rx_data_i   received-byte pulse and byte
//   spi_tx_data_o, spi_tx_valid_o   next byte to shift out and its freshness
//   wb_addr_o, wb_data_o, wb_data_i Wishbone address / write / read data
//   wb_we_o, wb_cycle_o, wb_strobe_o, wb_ack_i, wb_stall_i  bus controls
//   overrun_o                       sticky: a byte arrived during a bus access
module spi_wb_bridge
  import common_pkg::*;
(
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic                     spi_cs_n_i,
  input  logic                     spi_rx_valid_i,
  input  logic [DATA_WIDTH-1:0]    spi_rx_data_i,
  output logic [DATA_WIDTH-1:0]    spi_tx_data_o,
  output logic                     spi_tx_valid_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic                     wb_we_o,
  output logic                     wb_cycle_o,
  output logic                     wb_strobe_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_stall_i,
  output logic                     overrun_o
);

  spi_wb_state_t state_q, state_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     is_write_q, is_write_d;
  logic                     incr_q, incr_d;
  logic                     abort_q, abort_d;
  logic                     cs_n_prev_q, cs_n_prev_d;

  logic rx;
  logic cs_fall;
  logic req;
  logic done;

  // Bytes seen while chip select is high never reach the FSM.
  assign rx      = spi_rx_valid_i && !spi_cs_n_i;
  assign cs_fall = cs_n_prev_q && !spi_cs_n_i;

  wb_master_port u_wb_master_port (
    .clk         (wb_clock_i),
    .rst         (wb_reset_i),
    .req_i       (req),
    .we_i        (is_write_q),
    .wb_stall_i  (wb_stall_i),
    .wb_ack_i    (wb_ack_i),
    .wb_cycle_o  (wb_cycle_o),
    .wb_strobe_o (wb_strobe_o),
    .wb_we_o     (wb_we_o),
    .done_o      (done)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    overrun_d   = overrun_q;
    is_write_d  = is_write_q;
    incr_d      = incr_q;
    abort_d     = abort_q;
    cs_n_prev_d = spi_cs_n_i;
    req         = 1'b0;

    // Frame start clears the sticky overrun; a same-cycle overrun below wins.
    if (cs_fall) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (rx) begin
          is_write_d                            = spi_rx_data_i[SPI_CMD_WRITE_BIT];
          incr_d                                = spi_rx_data_i[SPI_CMD_INCR_BIT];
          addr_d[WB_ADDR_WIDTH-1:16]            = spi_rx_data_i[3:0];
          state_d                               = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        if (spi_cs_n_i) begin
          state_d = ST_IDLE;
        end else if (rx) begin
          addr_d[15:8] = spi_rx_data_i;
          state_d      = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (spi_cs_n_i) begin
          state_d = ST_IDLE;
        end else if (rx) begin
          addr_d[7:0] = spi_rx_data_i;
          if (is_write_q) begin
            state_d = ST_DATA;
          end else begin
            // Reads prefetch immediately so the first byte is ready to shift.
            req     = 1'b1;
            state_d = ST_WB_REQ;
          end
        end
      end
      ST_DATA: begin
        if (spi_cs_n_i) begin
          state_d = ST_IDLE;
        end else if (rx) begin
          if (is_write_q) begin
            wdata_d = spi_rx_data_i;
          end else begin
            // Dummy byte: the previous read has been shifted out.
            tx_valid_d = 1'b0;
          end
          req     = 1'b1;
          state_d = ST_WB_REQ;
        end
      end
      ST_WB_REQ: begin
        if (rx) begin
          overrun_d = 1'b1;
        end
        if (spi_cs_n_i) begin
          abort_d = 1'b1;
        end
        if (!wb_stall_i) begin
          state_d = ST_WB_WAIT;
        end
      end
      ST_WB_WAIT: begin
        if (rx) begin
          overrun_d = 1'b1;
        end
        if (spi_cs_n_i) begin
          abort_d = 1'b1;
        end
        // An open bus cycle always runs to its ack, even after cs_n rises.
        if (done) begin
          if (!is_write_q) begin
            tx_data_d  = wb_data_i;
            tx_valid_d = 1'b1;
          end
          if (incr_q) begin
            addr_d = addr_q + 1'b1;
          end
          state_d = (abort_q || spi_cs_n_i) ? ST_IDLE : ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      is_write_q  <= 1'b0;
      incr_q      <= 1'b0;
      abort_q     <= 1'b0;
      cs_n_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      overrun_q   <= overrun_d;
      is_write_q  <= is_write_d;
      incr_q      <= incr_d;
      abort_q     <= abort_d;
      cs_n_prev_q <= cs_n_prev_d;
    end
  end

  assign wb_addr_o      = addr_q;
  assign wb_data_o      = wdata_q;
  assign spi_tx_data_o  = tx_data_q;
  assign spi_tx_valid_o = tx_valid_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Directed bench for spi_wb_bridge with a small pipelined Wishbone slave.
module tb_spi_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs_n_i;
  logic        spi_rx_valid_i;
  logic [7:0]  spi_rx_data_i;
  logic [7:0]  spi_tx_data_o;
  logic        spi_tx_valid_o;
  logic [19:0] wb_addr_o;
  logic [7:0]  wb_data_o;
  logic [7:0]  wb_data_i = 8'h00;
  logic        wb_we_o;
  logic        wb_cycle_o;
  logic        wb_strobe_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_stall_i;
  logic        overrun_o;

  always #5 clk = ~clk;

  spi_wb_bridge dut (
    .wb_clock_i     (clk),
    .wb_reset_i     (rst),
    .spi_cs_n_i     (spi_cs_n_i),
    .spi_rx_valid_i (spi_rx_valid_i),
    .spi_rx_data_i  (spi_rx_data_i),
    .spi_tx_data_o  (spi_tx_data_o),
    .spi_tx_valid_o (spi_tx_valid_o),
    .wb_addr_o      (wb_addr_o),
    .wb_data_o      (wb_data_o),
    .wb_data_i      (wb_data_i),
    .wb_we_o        (wb_we_o),
    .wb_cycle_o     (wb_cycle_o),
    .wb_strobe_o    (wb_strobe_o),
    .wb_ack_i       (wb_ack_i),
    .wb_stall_i     (wb_stall_i),
    .overrun_o      (overrun_o)
  );

  // Slave configuration, written only by the stimulus block.
  int cfg_stall = 0;
  int cfg_ack   = 1;
  logic [7:0] rd_tab [0:7];

  // Slave state and monitors, written only by the slave block.
  int stall_seen = 0;
  int ack_wait   = 0;
  int txn_cnt    = 0;
  int stb_cycles = 0;
  int ack_cnt    = 0;
  int txv_pulses = 0;
  int proto_err  = 0;
  logic txv_prev = 1'b0;
  logic [19:0] log_addr [0:63];
  logic        log_we   [0:63];
  logic [7:0]  log_dat  [0:63];

  assign wb_stall_i = wb_strobe_o && (stall_seen < cfg_stall);

  always @(posedge clk) begin
    wb_ack_i <= 1'b0;
    if (ack_wait != 0) begin
      ack_wait <= ack_wait - 1;
      if (ack_wait == 1) wb_ack_i <= 1'b1;
    end
    if (wb_cycle_o && wb_strobe_o && !wb_stall_i) begin
      log_addr[txn_cnt[5:0]] <= wb_addr_o;
      log_we[txn_cnt[5:0]]   <= wb_we_o;
      log_dat[txn_cnt[5:0]]  <= wb_data_o;
      txn_cnt    <= txn_cnt + 1;
      wb_data_i  <= rd_tab[wb_addr_o[2:0]];
      stall_seen <= 0;
      if (cfg_ack <= 1) wb_ack_i <= 1'b1;
      else ack_wait <= cfg_ack - 1;
    end else if (wb_strobe_o) begin
      stall_seen <= stall_seen + 1;
    end else begin
      stall_seen <= 0;
    end
    if (wb_strobe_o) stb_cycles <= stb_cycles + 1;
    if (wb_strobe_o && !wb_cycle_o) proto_err <= proto_err + 1;
    if (wb_cycle_o && wb_ack_i) ack_cnt <= ack_cnt + 1;
    txv_prev <= spi_tx_valid_o;
    if (spi_tx_valid_o && !txv_prev) txv_pulses <= txv_pulses + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one byte for exactly one clock, returns on the following
  // falling edge (one edge after the DUT sampled it), then idles gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    spi_rx_valid_i = 1'b1;
    spi_rx_data_i  = b;
    @(negedge clk);
    spi_rx_valid_i = 1'b0;
    spi_rx_data_i  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int b_txn, b_stb, b_ack, b_txv;
  int waited;

  initial begin
    rd_tab[0] = 8'h11; rd_tab[1] = 8'h22; rd_tab[2] = 8'h33; rd_tab[3] = 8'h44;
    rd_tab[4] = 8'h55; rd_tab[5] = 8'h66; rd_tab[6] = 8'h77; rd_tab[7] = 8'h88;
    rst = 1'b1;
    spi_cs_n_i = 1'b1;
    spi_rx_valid_i = 1'b0;
    spi_rx_data_i = 8'h00;
    idle(3);

    // Reset state
    check("rst_cyc", wb_cycle_o, 0);
    check("rst_stb", wb_strobe_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_addr", wb_addr_o, 0);
    check("rst_data", wb_data_o, 0);
    check("rst_txd", spi_tx_data_o, 0);
    check("rst_txv", spi_tx_valid_o, 0);
    check("rst_ovr", overrun_o, 0);
    rst = 1'b0;
    idle(2);

    // Byte with cs_n high is ignored: cmd nibble F must not reach addr[19:16]
    send(8'h8F, 2);
    check("ign_addr", wb_addr_o, 20'h00000);
    check("ign_cyc", wb_cycle_o, 0);

    // Write C1 01 23 5A, auto-increment, slave ack +1
    spi_cs_n_i = 1'b0; idle(2);
    b_txn = txn_cnt; b_stb = stb_cycles;
    send(8'hC1, 3); send(8'h01, 3); send(8'h23, 3);
    send(8'h5A, 0);
    check("wr_lat_stb", wb_strobe_o, 1);
    check("wr_lat_cyc", wb_cycle_o, 1);
    check("wr_lat_we", wb_we_o, 1);
    check("wr_lat_dat", wb_data_o, 8'h5A);
    idle(6);
    check("wr_ntxn", txn_cnt - b_txn, 1);
    check("wr_nstb", stb_cycles - b_stb, 1);
    check("wr_addr", log_addr[b_txn], 20'h10123);
    check("wr_we", log_we[b_txn], 1);
    check("wr_dat", log_dat[b_txn], 8'h5A);
    check("wr_incr", wb_addr_o, 20'h10124);
    check("wr_cyc_end", wb_cycle_o, 0);
    spi_cs_n_i = 1'b1; idle(3);

    // Read 40 00 10 with auto-increment, then dummy bytes
    spi_cs_n_i = 1'b0; idle(2);
    b_txn = txn_cnt; b_txv = txv_pulses;
    send(8'h40, 3); send(8'h00, 3);
    send(8'h10, 0);
    check("rd_lat_stb", wb_strobe_o, 1);
    check("rd_lat_we", wb_we_o, 0);
    check("rd_lat_addr", wb_addr_o, 20'h00010);
    idle(4);
    check("rd1_txd", spi_tx_data_o, 8'h11);
    check("rd1_txv", spi_tx_valid_o, 1);
    check("rd1_addr", wb_addr_o, 20'h00011);
    send(8'h00, 0);
    check("rd2_txv_clr", spi_tx_valid_o, 0);
    check("rd2_stb", wb_strobe_o, 1);
    idle(4);
    check("rd2_txd", spi_tx_data_o, 8'h22);
    check("rd2_txv", spi_tx_valid_o, 1);
    check("rd_pulses", txv_pulses - b_txv, 2);
    check("rd_addr0", log_addr[b_txn], 20'h00010);
    check("rd_addr1", log_addr[b_txn + 1], 20'h00011);
    check("rd_we0", log_we[b_txn], 0);
    send(8'h00, 5);
    spi_cs_n_i = 1'b1; idle(3);

    // Stall for 3 cycles: strobe high 4 cycles, one access, one ack
    cfg_stall = 3;
    spi_cs_n_i = 1'b0; idle(2);
    b_txn = txn_cnt; b_stb = stb_cycles; b_ack = ack_cnt;
    send(8'h80, 3); send(8'h00, 3); send(8'h40, 3);
    send(8'hA5, 2);
    check("st_hold_stb", wb_strobe_o, 1);
    idle(8);
    check("st_nstb", stb_cycles - b_stb, 4);
    check("st_ntxn", txn_cnt - b_txn, 1);
    check("st_nack", ack_cnt - b_ack, 1);
    check("st_addr", log_addr[b_txn], 20'h00040);
    check("st_dat", log_dat[b_txn], 8'hA5);
    check("st_noinc", wb_addr_o, 20'h00040);
    cfg_stall = 0;
    spi_cs_n_i = 1'b1; idle(3);

    // Auto-increment write wrapping from 0xFFFFF to 0x00000
    spi_cs_n_i = 1'b0; idle(2);
    b_txn = txn_cnt;
    send(8'hCF, 3); send(8'hFF, 3); send(8'hFF, 3);
    send(8'hAA, 6); send(8'hBB, 6);
    check("wrap_ntxn", txn_cnt - b_txn, 2);
    check("wrap_addr0", log_addr[b_txn], 20'hFFFFF);
    check("wrap_dat0", log_dat[b_txn], 8'hAA);
    check("wrap_addr1", log_addr[b_txn + 1], 20'h00000);
    check("wrap_dat1", log_dat[b_txn + 1], 8'hBB);
    check("wrap_next", wb_addr_o, 20'h00001);
    spi_cs_n_i = 1'b1; idle(3);

    // Overrun: byte during a 5-cycle ack delay is dropped and flagged
    cfg_ack = 5;
    spi_cs_n_i = 1'b0; idle(2);
    b_txn = txn_cnt;
    send(8'h80, 3); send(8'h00, 3); send(8'h50, 3);
    send(8'h77, 1);
    send(8'h99, 0);
    check("ovr_set", overrun_o, 1);
    check("ovr_cyc", wb_cycle_o, 1);
    check("ovr_dat", wb_data_o, 8'h77);
    idle(10);
    check("ovr_ntxn", txn_cnt - b_txn, 1);
    check("ovr_sticky", overrun_o, 1);
    spi_cs_n_i = 1'b1; idle(2);
    check("ovr_cs_hi", overrun_o, 1);
    spi_cs_n_i = 1'b0; idle(2);
    check("ovr_clr", overrun_o, 0);
    spi_cs_n_i = 1'b1; idle(3);

    // Abort: cs_n rises in WB_WAIT, cycle held until ack, then IDLE
    spi_cs_n_i = 1'b0; idle(2);
    send(8'h80, 3); send(8'h00, 3); send(8'h60, 3);
    send(8'h12, 1);
    spi_cs_n_i = 1'b1;
    idle(2);
    check("ab_hold_cyc", wb_cycle_o, 1);
    waited = 0;
    while (wb_cycle_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ab_ack_in_time", (waited < 20), 1);
    check("ab_cyc_drop", wb_cycle_o, 0);
    cfg_ack = 1;
    idle(2);
    spi_cs_n_i = 1'b0; idle(2);
    b_txn = txn_cnt;
    send(8'h80, 3); send(8'h00, 3); send(8'h70, 3);
    send(8'h34, 6);
    check("ab_next_ntxn", txn_cnt - b_txn, 1);
    check("ab_next_addr", log_addr[b_txn], 20'h00070);
    check("ab_next_dat", log_dat[b_txn], 8'h34);
    spi_cs_n_i = 1'b1; idle(3);

    // Asynchronous reset during a stalled strobe
    cfg_stall = 5;
    spi_cs_n_i = 1'b0; idle(2);
    send(8'h80, 3); send(8'h00, 3); send(8'h80, 3);
    send(8'h56, 0);
    check("ar_pre_stb", wb_strobe_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_cyc", wb_cycle_o, 0);
    check("ar_stb", wb_strobe_o, 0);
    check("ar_addr", wb_addr_o, 0);
    @(negedge clk);
    rst = 1'b0;
    cfg_stall = 0;
    spi_cs_n_i = 1'b1; idle(3);

    // Non-incrementing read after reset
    spi_cs_n_i = 1'b0; idle(2);
    b_txn = txn_cnt;
    send(8'h00, 3); send(8'h00, 3);
    send(8'h90, 4);
    check("rd_ni_txd", spi_tx_data_o, 8'h11);
    check("rd_ni_txv", spi_tx_valid_o, 1);
    check("rd_ni_addr", log_addr[b_txn], 20'h00090);
    check("rd_ni_hold", wb_addr_o, 20'h00090);
    spi_cs_n_i = 1'b1; idle(3);

    check("proto_stb_wo_cyc", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
